bcd_seven_seg_scan: RTL

Four-digit multiplexed seven-segment display driver that consumes the 4-bit BCD counter outputs. Up to four cascaded BCD digits are presented on `digits`. Each frame, the block snapshots them and time-multiplexes them onto one shared segment bus with active-low digit anodes. It adds optional leading-zero blanking, per-digit decimal points and a frame-done strobe.

---
 rtl/bcd_seven_seg_scan.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bcd_seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver. It snapshots BCD digits and
// decimal points once per frame and scans them out on active-low anodes.
module bcd_seven_seg_scan #(
   parameter int PRESCALE = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] digits,
   input  logic        blank_en,
   input  logic [3:0]  dp_mask,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_done
);

   localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

   logic [CW-1:0] pcnt_q, pcnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   snap_dig_q, snap_dig_d;
   logic [3:0]    snap_dp_q, snap_dp_d;
   logic          load_pend_q, load_pend_d;
   logic          valid_q, valid_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [3:0]    an_q, an_d;
   logic          frame_done_q, frame_done_d;

   logic          tick;
   logic          frame_end;
   logic [3:0]    cur_nib;
   logic [3:0]    upper_zero;
   logic          blanked;

   function automatic logic [6:0] decode(input logic [3:0] code);
      case (code)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h40;
      endcase
   endfunction

   always_comb begin
      pcnt_d       = pcnt_q + CW'(1);
      idx_d        = idx_q;
      snap_dig_d   = snap_dig_q;
      snap_dp_d    = snap_dp_q;
      load_pend_d  = load_pend_q;
      valid_d      = valid_q;
      seg_d        = 7'h00;
      dp_d         = 1'b0;
      an_d         = 4'b1111;

      tick      = (pcnt_q == CW'(PRESCALE - 1));
      frame_end = tick && (idx_q == 2'd3);

      if (tick) begin
         pcnt_d = '0;
         idx_d  = idx_q + 2'd1;
      end

      // A new frame's snapshot is taken right after reset and at every frame wrap.
      if (load_pend_q || frame_end) begin
         snap_dig_d  = digits;
         snap_dp_d   = dp_mask;
         load_pend_d = 1'b0;
         valid_d     = 1'b1;
      end

      frame_done_d = frame_end;

      // upper_zero[i]: snapshot digits i..3 are all zero; digit 0 is never blankable.
      upper_zero[3] = (snap_dig_q[15:12] == 4'd0);
      upper_zero[2] = upper_zero[3] && (snap_dig_q[11:8] == 4'd0);
      upper_zero[1] = upper_zero[2] && (snap_dig_q[7:4] == 4'd0);
      upper_zero[0] = 1'b0;

      cur_nib = snap_dig_q[{idx_q, 2'b00} +: 4];
      blanked = blank_en && upper_zero[idx_q] && !snap_dp_q[idx_q];

      if (valid_q && !blanked) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = decode(cur_nib);
         dp_d  = snap_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pcnt_q       <= '0;
         idx_q        <= 2'd0;
         snap_dig_q   <= 16'h0000;
         snap_dp_q    <= 4'h0;
         load_pend_q  <= 1'b1;
         valid_q      <= 1'b0;
         seg_q        <= 7'h00;
         dp_q         <= 1'b0;
         an_q         <= 4'b1111;
         frame_done_q <= 1'b0;
      end else begin
         pcnt_q       <= pcnt_d;
         idx_q        <= idx_d;
         snap_dig_q   <= snap_dig_d;
         snap_dp_q    <= snap_dp_d;
         load_pend_q  <= load_pend_d;
         valid_q      <= valid_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule
